fsm_pattern_detector_param: RTL and testbench

- Parametrised serial sequence detector: successor to the fixed 5-symbol Bike/Car detector.
- Monitors a 1-bit stream qualified by valid_in and pulses pattern_flag when the last cfg_len accepted bits equal a run-time programmable pattern.
- Adds selectable overlap/non-overlap matching and a saturating match counter for the traffic-monitor datapath.

---
 rtl/fsm_pattern_detector_param.sv | 73 +++++++
 tb/tb_fsm_pattern_detector_param.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/fsm_pattern_detector_param.sv
// fsm_pattern_detector_param: programmable serial pattern detector with overlap control and saturating match counter
module fsm_pattern_detector_param #(
    parameter int                 MAX_LEN         = 8,
    parameter logic [MAX_LEN-1:0] DEFAULT_PATTERN = MAX_LEN'(8'b0001_1010),
    parameter int                 DEFAULT_LEN     = 5,
    parameter bit                 OVERLAP         = 1'b1,
    parameter int                 COUNT_W         = 8,
    localparam int                LEN_W           = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    input  logic               d_in,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               clr_count,
    output logic               pattern_flag,
    output logic [COUNT_W-1:0] match_count,
    output logic               count_sat
);
    localparam logic [LEN_W-1:0]   MAX_L = LEN_W'(MAX_LEN);
    localparam logic [COUNT_W-1:0] ONES  = '1;

    logic [MAX_LEN-1:0] hist, pat, nh, mask;
    logic [LEN_W-1:0]   fill, len, fill_inc, len_cfg;
    logic [COUNT_W-1:0] count_inc;
    logic               match;

    // next history, active-length mask, match decision and saturating increments
    always_comb begin
        nh = {hist[MAX_LEN-2:0], d_in};
        for (int i = 0; i < MAX_LEN; i++) mask[i] = i < int'(len);
        match = valid_in && (({1'b0, fill} + 1'b1) >= {1'b0, len}) && ((nh & mask) == (pat & mask));
        fill_inc = (fill == MAX_L) ? fill : fill + 1'b1;
        len_cfg = (cfg_len == '0) ? LEN_W'(1) : (cfg_len > MAX_L) ? MAX_L : cfg_len;
        count_inc = (match_count == ONES) ? match_count : match_count + 1'b1;
    end

    // configuration, history shifting, match pulse and counter update
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hist         <= '0;
            fill         <= '0;
            pat          <= DEFAULT_PATTERN;
            len          <= LEN_W'(DEFAULT_LEN);
            pattern_flag <= 1'b0;
            match_count  <= '0;
            count_sat    <= 1'b0;
        end else if (cfg_load) begin
            pat          <= cfg_pattern;
            len          <= len_cfg;
            hist         <= '0;
            fill         <= '0;
            pattern_flag <= 1'b0;
            match_count  <= '0;
            count_sat    <= 1'b0;
        end else begin
            pattern_flag <= match;
            if (valid_in) begin
                hist <= nh;
                fill <= (!OVERLAP && match) ? '0 : fill_inc;
            end
            if (match) begin
                match_count <= clr_count ? COUNT_W'(1) : count_inc;
                count_sat   <= clr_count ? 1'b0 : (count_sat || count_inc == ONES);
            end else if (clr_count) begin
                match_count <= '0;
                count_sat   <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fsm_pattern_detector_param.sv
// tb_fsm_pattern_detector_param: directed and random checks of three detector variants against a queue-based model
module tb_fsm_pattern_detector_param;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       valid_in = 1'b0, d_in = 1'b0, cfg_load = 1'b0, clr_count = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       flag0, flag1, flag2, sat0, sat1, sat2;
    logic [7:0] cnt0, cnt1;
    logic [1:0] cnt2;
    int         checks = 0, errors = 0;

    logic [7:0] m_pat;
    int         m_len;
    bit         q_ov[$], q_no[$];
    bit         ef[3];
    int         ec[3];
    bit         es[3];
    int         cmax[3] = '{255, 255, 3};

    always #5 clk = ~clk;

    fsm_pattern_detector_param u0 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .d_in(d_in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .clr_count(clr_count),
        .pattern_flag(flag0), .match_count(cnt0), .count_sat(sat0));
    fsm_pattern_detector_param #(.OVERLAP(1'b0)) u1 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .d_in(d_in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .clr_count(clr_count),
        .pattern_flag(flag1), .match_count(cnt1), .count_sat(sat1));
    fsm_pattern_detector_param #(.COUNT_W(2)) u2 (
        .clk(clk), .reset(reset), .valid_in(valid_in), .d_in(d_in), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .clr_count(clr_count),
        .pattern_flag(flag2), .match_count(cnt2), .count_sat(sat2));

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_flag0"}, int'(flag0), int'(ef[0]));
        chk({tag, "_cnt0"},  int'(cnt0),  ec[0]);
        chk({tag, "_sat0"},  int'(sat0),  int'(es[0]));
        chk({tag, "_flag1"}, int'(flag1), int'(ef[1]));
        chk({tag, "_cnt1"},  int'(cnt1),  ec[1]);
        chk({tag, "_sat1"},  int'(sat1),  int'(es[1]));
        chk({tag, "_flag2"}, int'(flag2), int'(ef[2]));
        chk({tag, "_cnt2"},  int'(cnt2),  ec[2]);
        chk({tag, "_sat2"},  int'(sat2),  int'(es[2]));
    endtask

    function automatic bit qmatch(input bit q[$]);
        if (q.size() < m_len) return 1'b0;
        for (int i = 0; i < m_len; i++) if (q[q.size() - 1 - i] != m_pat[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_clear();
        q_ov.delete();
        q_no.delete();
        for (int k = 0; k < 3; k++) begin ef[k] = 0; ec[k] = 0; es[k] = 0; end
    endfunction

    task automatic step(input string tag, input bit v, input bit d, input bit ld = 0, input bit clr = 0,
                        input logic [7:0] cp = 8'h00, input logic [3:0] cl = 4'd0);
        bit mo, mn;
        valid_in = v; d_in = d; cfg_load = ld; clr_count = clr; cfg_pattern = cp; cfg_len = cl;
        if (ld) begin
            m_pat = cp;
            m_len = (cl == 0) ? 1 : (cl > 8) ? 8 : int'(cl);
            model_clear();
        end else begin
            mo = 0; mn = 0;
            if (v) begin
                q_ov.push_back(d);
                while (q_ov.size() > 8) void'(q_ov.pop_front());
                q_no.push_back(d);
                while (q_no.size() > 8) void'(q_no.pop_front());
                mo = qmatch(q_ov);
                mn = qmatch(q_no);
                if (mn) q_no.delete();
            end
            ef[0] = mo; ef[1] = mn; ef[2] = mo;
            for (int k = 0; k < 3; k++) begin
                if (ef[k]) begin
                    ec[k] = clr ? 1 : (ec[k] + 1 > cmax[k] ? cmax[k] : ec[k] + 1);
                    es[k] = clr ? 0 : (es[k] || ec[k] == cmax[k]);
                end else if (clr) begin
                    ec[k] = 0; es[k] = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        chk_all(tag);
        valid_in = 0; cfg_load = 0; clr_count = 0;
    endtask

    task automatic do_reset(input string tag);
        #3 reset = 1'b0;
        m_pat = 8'b0001_1010;
        m_len = 5;
        model_clear();
        #1 chk_all(tag);
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic stream(input string tag, input logic [7:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(tag, 1'b1, bits[i]);
    endtask

    initial begin
        m_pat = 8'b0001_1010;
        m_len = 5;
        model_clear();
        #12;
        chk_all("rst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        stream("tp1", 8'b11010, 5);
        chk("tp1_count", int'(cnt0), 1);

        do_reset("rst2");
        step("gap", 1, 1); step("gap", 1, 1);
        for (int i = 0; i < 3; i++) step("gap", 0, 1'($urandom));
        step("gap", 1, 0); step("gap", 1, 1); step("gap", 1, 0);
        chk("gap_count", int'(cnt0), 1);

        step("ld101", 0, 0, 1, 0, 8'b101, 4'd3);
        stream("ov", 8'b10101, 5);
        chk("ov_count", int'(cnt0), 2);
        chk("nov_count", int'(cnt1), 1);

        step("ld1", 0, 0, 1, 0, 8'b1, 4'd1);
        for (int i = 0; i < 6; i++) step("sat", 1, 1);
        chk("sat_count", int'(cnt2), 3);
        chk("sat_flag", int'(sat2), 1);
        step("clrm", 1, 1, 0, 1);
        chk("clrm_count", int'(cnt2), 1);
        chk("clrm_sat", int'(sat2), 0);

        step("len0", 0, 0, 1, 0, 8'b0000_0001, 4'd0);
        step("len0", 1, 0); step("len0", 1, 1);
        step("lenmax", 0, 0, 1, 1, 8'hA5, 4'd11);
        stream("lenmax", 8'hA5, 8);
        chk("lenmax_flag", int'(flag0), 1);

        step("ldd", 0, 0, 1, 0, 8'b0001_1010, 4'd5);
        stream("pre", 8'b11010, 5);
        stream("pre", 8'b1101, 4);
        do_reset("arst");
        step("post0", 1, 0);
        stream("post", 8'b11010, 5);
        chk("post_count", int'(cnt0), 1);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0)
                step("rnd", 0, 0, 1, 0, 8'($urandom), 4'($urandom_range(0, 10)));
            else
                step("rnd", 1'($urandom_range(0, 3) != 0), 1'($urandom), 0, 1'($urandom_range(0, 29) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
